// File: rtl/score_table_master.sv
// score_table_master: writes each final score into a ring of table slots, then scans
// the valid slots to publish the best score; also rescans on an explicit query.
module score_table_master #(
  parameter int READ_LATENCY = 1,
  parameter int DEPTH = 32
) (
  input  logic       i_Clk,
  input  logic       i_Rst_L,
  input  logic       i_Game_Over,
  input  logic [3:0] i_Score,
  input  logic       i_Query,
  output logic       o_write_en,
  output logic [4:0] o_write_addr,
  output logic [7:0] o_write_data,
  output logic       o_read_en,
  output logic [4:0] o_read_addr,
  input  logic [7:0] i_read_data,
  output logic [3:0] o_Best_Score,
  output logic       o_Best_Valid,
  output logic [5:0] o_Entry_Count,
  output logic       o_Busy,
  output logic       o_Drop
);
  typedef enum logic [2:0] {IDLE, WRITE, SCAN, DRAIN, DONE} state_t;
  state_t state_q;
  logic [4:0] ptr_q, wr_addr_q, rd_addr_q;
  logic [5:0] cnt_q;
  logic [7:0] wr_data_q;
  logic [3:0] pend_score_q, max_q, max_d, best_q;
  logic wr_en_q, rd_en_q, pend_q, drop_q, best_valid_q;
  logic [READ_LATENCY-1:0] vld_q, vld_d;
  logic [READ_LATENCY:0] vld_sh;
  logic busy, pend_take, hit, last_rd;
  // vld_q tracks which issued reads are still in flight; the top bit marks data arriving now
  assign vld_sh = {vld_q, rd_en_q};
  assign vld_d = vld_sh[READ_LATENCY-1:0];
  assign hit = vld_q[READ_LATENCY-1] && i_read_data[7];
  assign max_d = (hit && i_read_data[3:0] > max_q) ? i_read_data[3:0] : max_q;
  assign last_rd = {1'b0, rd_addr_q} == cnt_q - 6'd1;
  assign busy = state_q != IDLE;
  assign pend_take = state_q == DONE && pend_q;
  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      state_q <= IDLE;
      ptr_q <= '0;
      wr_addr_q <= '0;
      rd_addr_q <= '0;
      cnt_q <= '0;
      wr_data_q <= '0;
      pend_score_q <= '0;
      max_q <= '0;
      best_q <= '0;
      wr_en_q <= 1'b0;
      rd_en_q <= 1'b0;
      pend_q <= 1'b0;
      drop_q <= 1'b0;
      best_valid_q <= 1'b0;
      vld_q <= '0;
    end else begin
      wr_en_q <= 1'b0;
      drop_q <= 1'b0;
      vld_q <= vld_d;
      max_q <= max_d;
      // the pending slot frees in DONE, so a game-over in that same cycle can refill it
      if (i_Game_Over && busy) begin
        if (pend_q && !pend_take) drop_q <= 1'b1;
        else begin
          pend_q <= 1'b1;
          pend_score_q <= i_Score;
        end
      end else if (pend_take) pend_q <= 1'b0;
      case (state_q)
        IDLE:
          if (i_Game_Over) begin
            state_q <= WRITE;
            wr_en_q <= 1'b1;
            wr_addr_q <= ptr_q;
            wr_data_q <= {4'b1000, i_Score};
          end else if (i_Query) begin
            state_q <= SCAN;
            rd_en_q <= cnt_q != 6'd0;
            rd_addr_q <= '0;
            max_q <= '0;
          end
        WRITE: begin
          state_q <= SCAN;
          ptr_q <= ptr_q + 5'd1;
          cnt_q <= (cnt_q == 6'(DEPTH)) ? cnt_q : cnt_q + 6'd1;
          rd_en_q <= 1'b1;
          rd_addr_q <= '0;
          max_q <= '0;
        end
        SCAN:
          if (!rd_en_q) state_q <= DONE;
          else if (last_rd) begin
            rd_en_q <= 1'b0;
            state_q <= DRAIN;
          end else rd_addr_q <= rd_addr_q + 5'd1;
        DRAIN:
          if (vld_d == '0) state_q <= DONE;
        DONE: begin
          best_q <= max_q;
          best_valid_q <= cnt_q != 6'd0;
          if (pend_q) begin
            state_q <= WRITE;
            wr_en_q <= 1'b1;
            wr_addr_q <= ptr_q;
            wr_data_q <= {4'b1000, pend_score_q};
          end else state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign o_write_en = wr_en_q;
  assign o_write_addr = wr_addr_q;
  assign o_write_data = wr_data_q;
  assign o_read_en = rd_en_q;
  assign o_read_addr = rd_addr_q;
  assign o_Best_Score = best_q;
  assign o_Best_Valid = best_valid_q;
  assign o_Entry_Count = cnt_q;
  assign o_Busy = busy;
  assign o_Drop = drop_q;
endmodule

// File: tb/tb_score_table_master.sv
// tb_score_table_master: scoreboard bench for score_table_master with a latency-RL table model.
module tb_score_table_master;
  localparam int RL = 3;
  logic clk = 0, rst_l = 0, go = 0, query = 0;
  logic [3:0] score = 0;
  logic o_write_en, o_read_en, o_Best_Valid, o_Busy, o_Drop;
  logic [4:0] o_write_addr, o_read_addr;
  logic [7:0] o_write_data, rdata;
  logic [3:0] o_Best_Score;
  logic [5:0] o_Entry_Count;
  logic [7:0] mem [32];
  logic [7:0] pipe [RL];
  logic [12:0] wq[$];
  logic [4:0] rq[$];
  int n_chk = 0, n_pass = 0, drops = 0;
  int mscore [32];
  int m_ptr = 0, m_cnt = 0;

  always #5 clk = ~clk;

  score_table_master #(.READ_LATENCY(RL), .DEPTH(32)) dut (
    .i_Clk(clk), .i_Rst_L(rst_l), .i_Game_Over(go), .i_Score(score), .i_Query(query),
    .o_write_en(o_write_en), .o_write_addr(o_write_addr), .o_write_data(o_write_data),
    .o_read_en(o_read_en), .o_read_addr(o_read_addr), .i_read_data(rdata),
    .o_Best_Score(o_Best_Score), .o_Best_Valid(o_Best_Valid), .o_Entry_Count(o_Entry_Count),
    .o_Busy(o_Busy), .o_Drop(o_Drop)
  );

  // table model: stale slots hold invalid words; idle read data looks like a valid 15
  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 8'h0F;
    for (int i = 0; i < RL; i++) pipe[i] = 8'h8F;
  end
  always @(posedge clk) begin
    if (o_write_en) mem[o_write_addr] <= o_write_data;
    pipe[0] <= o_read_en ? mem[o_read_addr] : 8'h8F;
    for (int i = 1; i < RL; i++) pipe[i] <= pipe[i-1];
  end
  assign rdata = pipe[RL-1];

  always @(negedge clk) begin
    logic [12:0] ew;
    logic [4:0] er;
    if (o_write_en || o_read_en) begin
      n_chk++;
      if (o_write_en && o_read_en) $display("FAIL strobe_overlap: both write and read strobes high");
      else n_pass++;
    end
    if (o_write_en) begin
      n_chk++;
      if (wq.size() == 0) $display("FAIL unexpected_write: addr %0d data %h, none required", o_write_addr, o_write_data);
      else begin
        ew = wq.pop_front();
        if ({o_write_addr, o_write_data} !== ew)
          $display("FAIL write: got addr %0d data %h, want addr %0d data %h", o_write_addr, o_write_data, ew[12:8], ew[7:0]);
        else n_pass++;
      end
    end
    if (o_read_en) begin
      n_chk++;
      if (rq.size() == 0) $display("FAIL unexpected_read: addr %0d, none required", o_read_addr);
      else begin
        er = rq.pop_front();
        if (o_read_addr !== er) $display("FAIL read_addr: got %0d want %0d", o_read_addr, er);
        else n_pass++;
      end
    end
    if (o_Drop) drops++;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset;
    rst_l = 0; go = 0; query = 0;
    tick(3);
    rst_l = 1;
    m_ptr = 0; m_cnt = 0; wq.delete(); rq.delete();
    tick(1);
  endtask

  task automatic push_scan;
    for (int i = 0; i < m_cnt; i++) rq.push_back(5'(i));
  endtask

  task automatic model_go(input logic [3:0] s);
    wq.push_back({5'(m_ptr), 4'b1000, s});
    mscore[m_ptr] = int'(s);
    m_ptr = (m_ptr + 1) % 32;
    if (m_cnt < 32) m_cnt++;
    push_scan();
  endtask

  function automatic int exp_best();
    int b = 0;
    for (int i = 0; i < m_cnt; i++) if (mscore[i] > b) b = mscore[i];
    return b;
  endfunction

  task automatic pulse_go(input logic [3:0] s);
    score = s; go = 1;
    tick(1);
    go = 0;
  endtask

  task automatic pulse_query;
    query = 1;
    tick(1);
    query = 0;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (o_Busy && n < 500) begin
      n++;
      tick(1);
    end
    if (o_Busy) begin
      n_chk++;
      $display("FAIL busy_timeout: still busy after %0d cycles", n);
    end
  endtask

  task automatic test_reset;
    rst_l = 0; go = 0; query = 0;
    tick(3);
    n_chk++;
    if ({o_write_en, o_write_addr, o_write_data, o_read_en, o_read_addr, o_Best_Score,
         o_Best_Valid, o_Entry_Count, o_Busy, o_Drop} !== 33'd0)
      $display("FAIL reset_outputs: some output nonzero in reset");
    else n_pass++;
    rst_l = 1;
    tick(2);
    n_chk++;
    if ({o_Busy, o_Entry_Count, o_Best_Valid} !== 8'd0)
      $display("FAIL post_reset_idle: busy %b count %0d valid %b, want 0 0 0", o_Busy, o_Entry_Count, o_Best_Valid);
    else n_pass++;
  endtask

  task automatic test_single;
    int n;
    do_reset();
    model_go(4'd5);
    pulse_go(4'd5);
    n_chk++;
    if (o_write_en !== 1'b1) $display("FAIL write_timing: o_write_en %b in cycle after game-over, want 1", o_write_en);
    else n_pass++;
    wait_idle(n);
    n_chk++;
    if (n !== 2 + 1 + RL) $display("FAIL single_busy_cycles: got %0d want %0d", n, 2 + 1 + RL);
    else n_pass++;
    n_chk++;
    if ({o_Best_Score, o_Best_Valid, o_Entry_Count} !== {4'd5, 1'b1, 6'd1})
      $display("FAIL single_result: best %0d valid %b count %0d, want 5 1 1", o_Best_Score, o_Best_Valid, o_Entry_Count);
    else n_pass++;
  endtask

  task automatic test_multi;
    int n;
    logic [3:0] s [3];
    s[0] = 4'd3; s[1] = 4'd9; s[2] = 4'd2;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      model_go(s[i]);
      pulse_go(s[i]);
      wait_idle(n);
      n_chk++;
      if (o_Best_Score !== 4'(exp_best()) || o_Entry_Count !== 6'(m_cnt))
        $display("FAIL multi_step%0d: best %0d count %0d, want %0d %0d", i, o_Best_Score, o_Entry_Count, exp_best(), m_cnt);
      else n_pass++;
    end
    push_scan();
    pulse_query();
    wait_idle(n);
    n_chk++;
    if (n !== m_cnt + RL + 1) $display("FAIL query_busy_cycles: got %0d want %0d", n, m_cnt + RL + 1);
    else n_pass++;
    n_chk++;
    if ({o_Best_Score, o_Best_Valid, o_Entry_Count} !== {4'd9, 1'b1, 6'd3})
      $display("FAIL multi_result: best %0d valid %b count %0d, want 9 1 3", o_Best_Score, o_Best_Valid, o_Entry_Count);
    else n_pass++;
  endtask

  task automatic test_wrap;
    int n;
    logic [3:0] s;
    do_reset();
    for (int i = 0; i < 33; i++) begin
      s = 4'($urandom_range(0, 14));
      model_go(s);
      pulse_go(s);
      wait_idle(n);
    end
    n_chk++;
    if (o_Entry_Count !== 6'd32) $display("FAIL wrap_count: got %0d want 32", o_Entry_Count);
    else n_pass++;
    n_chk++;
    if (o_Best_Score !== 4'(exp_best())) $display("FAIL wrap_best: got %0d want %0d", o_Best_Score, exp_best());
    else n_pass++;
    n_chk++;
    if (wq.size() + rq.size() != 0) $display("FAIL wrap_missing_strobes: %0d writes %0d reads never seen", wq.size(), rq.size());
    else n_pass++;
  endtask

  task automatic test_pending;
    int n;
    do_reset();
    drops = 0;
    model_go(4'd4);
    model_go(4'd7);
    pulse_go(4'd4);
    pulse_go(4'd7);
    pulse_go(4'd1);
    wait_idle(n);
    n_chk++;
    if (drops !== 1) $display("FAIL drop_pulses: got %0d want 1", drops);
    else n_pass++;
    n_chk++;
    if ({o_Best_Score, o_Entry_Count} !== {4'd7, 6'd2})
      $display("FAIL pending_result: best %0d count %0d, want 7 2", o_Best_Score, o_Entry_Count);
    else n_pass++;
    n_chk++;
    if (wq.size() + rq.size() != 0) $display("FAIL pending_missing_strobes: %0d writes %0d reads never seen", wq.size(), rq.size());
    else n_pass++;
  endtask

  task automatic test_query_empty;
    int n;
    do_reset();
    pulse_query();
    wait_idle(n);
    n_chk++;
    if (n !== 2) $display("FAIL empty_busy_cycles: got %0d want 2", n);
    else n_pass++;
    n_chk++;
    if ({o_Best_Score, o_Best_Valid, o_Entry_Count} !== 11'd0)
      $display("FAIL empty_result: best %0d valid %b count %0d, want 0 0 0", o_Best_Score, o_Best_Valid, o_Entry_Count);
    else n_pass++;
  endtask

  task automatic test_reset_mid_scan;
    int n, k;
    do_reset();
    model_go(4'd6);
    pulse_go(4'd6);
    wait_idle(n);
    model_go(4'd8);
    pulse_go(4'd8);
    k = 0;
    while (!o_read_en && k < 20) begin
      k++;
      tick(1);
    end
    n_chk++;
    if (!o_read_en) $display("FAIL scan_start_timeout: no read strobe within 20 cycles");
    else n_pass++;
    rst_l = 0;
    tick(1);
    n_chk++;
    if ({o_write_en, o_write_addr, o_write_data, o_read_en, o_read_addr, o_Best_Score,
         o_Best_Valid, o_Entry_Count, o_Busy, o_Drop} !== 33'd0)
      $display("FAIL midscan_reset_outputs: busy %b read_en %b best %0d count %0d, want all 0",
               o_Busy, o_read_en, o_Best_Score, o_Entry_Count);
    else n_pass++;
    rq.delete(); wq.delete();
    m_ptr = 0; m_cnt = 0;
    tick(2);
    rst_l = 1;
    tick(RL + 1);
    pulse_query();
    wait_idle(n);
    n_chk++;
    if ({o_Best_Valid, o_Entry_Count, o_Best_Score} !== 11'd0 || n !== 2)
      $display("FAIL post_reset_query: valid %b count %0d best %0d busy %0d, want 0 0 0 2",
               o_Best_Valid, o_Entry_Count, o_Best_Score, n);
    else n_pass++;
  endtask

  initial begin
    tick(1);
    test_reset();
    test_single();
    test_multi();
    test_wrap();
    test_pending();
    test_query_empty();
    test_reset_mid_scan();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end
endmodule
